// File: rtl/issue_pick_age.sv
// Oldest-ready issue picker: age matrix over ENTRIES slots feeding one registered dispatch slot.
// Latency: o_en is combinational, and the picked op appears on o_valid/o_payload one cycle later.
// Backpressure: a held op stays stable while o_ready=0 and no new pick is made; bco_valid flushes it.
// Optional ALU bypass readiness is enabled by the ISSUE_PICK_FORWARD_EN macro.
module issue_pick_age #(
    parameter int ENTRIES   = 4,
    parameter int PAYLOAD_W = 64,
    parameter int ROB_W     = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           snoop_hit,
    input  logic                           bco_valid,
    input  logic [ENTRIES-1:0]             i_alloc,
    input  logic [ENTRIES-1:0]             i_valid,
    input  logic [ENTRIES-1:0]             i_src0_rdy,
    input  logic [ENTRIES-1:0]             i_src1_rdy,
    input  logic [ENTRIES*ROB_W-1:0]       i_src0_rob,
    input  logic [ENTRIES*ROB_W-1:0]       i_src1_rob,
    input  logic [ENTRIES-1:0]             i_mem,
    input  logic [ENTRIES*PAYLOAD_W-1:0]   i_payload,
    input  logic                           i_fwd_valid,
    input  logic [ROB_W-1:0]               i_fwd_rob,
    output logic [ENTRIES-1:0]             o_en,
    output logic                           o_valid,
    input  logic                           o_ready,
    output logic [$clog2(ENTRIES)-1:0]     o_entry,
    output logic [PAYLOAD_W-1:0]           o_payload,
    output logic                           o_src0_forward_alu,
    output logic                           o_src1_forward_alu
);

    localparam int IDX_W = $clog2(ENTRIES);

    // age[i][j] set means slot i is older than slot j
    logic [ENTRIES-1:0][ENTRIES-1:0] age;

    logic [ENTRIES-1:0]   src0_fwd;
    logic [ENTRIES-1:0]   src1_fwd;
    logic [ENTRIES-1:0]   ready;
    logic [ENTRIES-1:0]   cand;
    logic [ENTRIES-1:0]   pick;
    logic                 found;
    logic                 blocked;
    logic                 can_load;
    logic [IDX_W-1:0]     pick_idx;
    logic [PAYLOAD_W-1:0] pick_payload;
    logic                 pick_f0;
    logic                 pick_f1;

`ifdef ISSUE_PICK_FORWARD_EN
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            src0_fwd[i] = i_fwd_valid & ~i_src0_rdy[i] &
                          (i_src0_rob[i*ROB_W +: ROB_W] == i_fwd_rob);
            src1_fwd[i] = i_fwd_valid & ~i_src1_rdy[i] &
                          (i_src1_rob[i*ROB_W +: ROB_W] == i_fwd_rob);
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{i_fwd_valid, i_fwd_rob, i_src0_rob, i_src1_rob};
    assign src0_fwd   = '0;
    assign src1_fwd   = '0;
`endif

    assign can_load = ~o_valid | o_ready;

    always_comb begin
        ready        = '0;
        cand         = '0;
        pick         = '0;
        found        = 1'b0;
        blocked      = 1'b0;
        pick_idx     = '0;
        pick_payload = '0;
        pick_f0      = 1'b0;
        pick_f1      = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            ready[i] = i_valid[i] & ~i_alloc[i] &
                       (i_src0_rdy[i] | src0_fwd[i]) &
                       (i_src1_rdy[i] | src1_fwd[i]) &
                       ~(i_mem[i] & snoop_hit);
        end
        for (int i = 0; i < ENTRIES; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < ENTRIES; j++) begin
                if (j != i && ready[j] && age[j][i]) begin
                    blocked = 1'b1;
                end
            end
            cand[i] = ready[i] & ~blocked;
        end
        // Lowest-index tiebreak keeps the pick one-hot even if stale rows disagree.
        for (int i = 0; i < ENTRIES; i++) begin
            if (cand[i] && !found) begin
                found        = 1'b1;
                pick[i]      = 1'b1;
                pick_idx     = IDX_W'(i);
                pick_payload = i_payload[i*PAYLOAD_W +: PAYLOAD_W];
                pick_f0      = src0_fwd[i];
                pick_f1      = src1_fwd[i];
            end
        end
    end

    assign o_en = (can_load && !bco_valid && !reset) ? pick : '0;

    // New slots become younger than every live slot; same-cycle allocs order by index.
    always_ff @(posedge clk) begin
        if (reset) begin
            age <= '0;
        end else begin
            for (int r = 0; r < ENTRIES; r++) begin
                for (int c = 0; c < ENTRIES; c++) begin
                    if (r != c) begin
                        if (i_alloc[c]) begin
                            age[r][c] <= (i_valid[r] & ~i_alloc[r]) | (i_alloc[r] & (r < c));
                        end else if (i_alloc[r]) begin
                            age[r][c] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid            <= 1'b0;
            o_entry            <= '0;
            o_payload          <= '0;
            o_src0_forward_alu <= 1'b0;
            o_src1_forward_alu <= 1'b0;
        end else if (bco_valid) begin
            o_valid <= 1'b0;
        end else if (|o_en) begin
            o_valid            <= 1'b1;
            o_entry            <= pick_idx;
            o_payload          <= pick_payload;
            o_src0_forward_alu <= pick_f0;
            o_src1_forward_alu <= pick_f1;
        end else if (can_load) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_issue_pick_age.sv
// Directed bench for issue_pick_age: stimulus pushes expected dispatches, a monitor pops on handshake.
module tb_issue_pick_age;

    localparam int N  = 4;
    localparam int PW = 64;
    localparam int RW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              snoop_hit;
    logic              bco_valid;
    logic [N-1:0]      i_alloc;
    logic [N-1:0]      i_valid;
    logic [N-1:0]      i_src0_rdy;
    logic [N-1:0]      i_src1_rdy;
    logic [N*RW-1:0]   i_src0_rob;
    logic [N*RW-1:0]   i_src1_rob;
    logic [N-1:0]      i_mem;
    logic [N*PW-1:0]   i_payload;
    logic              i_fwd_valid;
    logic [RW-1:0]     i_fwd_rob;
    logic [N-1:0]      o_en;
    logic              o_valid;
    logic              o_ready;
    logic [1:0]        o_entry;
    logic [PW-1:0]     o_payload;
    logic              o_src0_forward_alu;
    logic              o_src1_forward_alu;

    issue_pick_age #(.ENTRIES(N), .PAYLOAD_W(PW), .ROB_W(RW)) dut (
        .clk(clk), .reset(reset), .snoop_hit(snoop_hit), .bco_valid(bco_valid),
        .i_alloc(i_alloc), .i_valid(i_valid), .i_src0_rdy(i_src0_rdy), .i_src1_rdy(i_src1_rdy),
        .i_src0_rob(i_src0_rob), .i_src1_rob(i_src1_rob), .i_mem(i_mem), .i_payload(i_payload),
        .i_fwd_valid(i_fwd_valid), .i_fwd_rob(i_fwd_rob), .o_en(o_en), .o_valid(o_valid),
        .o_ready(o_ready), .o_entry(o_entry), .o_payload(o_payload),
        .o_src0_forward_alu(o_src0_forward_alu), .o_src1_forward_alu(o_src1_forward_alu)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    entry;
        logic [PW-1:0] payload;
        logic          f0;
        logic          f1;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [PW-1:0] pl(input int k);
        return 64'hC0DE_0000_0F0F_0000 + 64'(k) * 64'h0000_0101_0000_0011;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] al, input logic [N-1:0] va,
                         input logic [N-1:0] rd, input logic [N-1:0] me);
        i_alloc    = al;
        i_valid    = va;
        i_src0_rdy = rd;
        i_src1_rdy = rd;
        i_mem      = me;
    endtask

    // Check o_en at the falling edge and queue the op it launches (if pushed).
    task automatic cyc(input string nm, input logic [N-1:0] e, input logic dopush, input logic f1);
        exp_t x;
        @(negedge clk);
        chk(nm, o_en, e);
        if (dopush && e != '0) begin
            x.entry = 2'd0;
            for (int k = 0; k < N; k++) if (e[k]) x.entry = 2'(k);
            x.payload = pl(int'(x.entry));
            x.f0      = 1'b0;
            x.f1      = f1;
            sb.push_back(x);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (!reset && o_valid && o_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mon_unexpected actual entry=%0d required none", o_entry);
                end else begin
                    x = sb.pop_front();
                    chk("mon_entry", o_entry, x.entry);
                    chk("mon_payload", o_payload, x.payload);
                    chk("mon_fwd0", o_src0_forward_alu, x.f0);
                    chk("mon_fwd1", o_src1_forward_alu, x.f1);
                end
            end
        end
    end

    initial begin : stim
        reset = 1'b1; snoop_hit = 1'b0; bco_valid = 1'b0; o_ready = 1'b1;
        i_src0_rob = '0; i_src1_rob = '0; i_fwd_valid = 1'b0; i_fwd_rob = '0;
        for (int k = 0; k < N; k++) i_payload[k*PW +: PW] = pl(k);
        drive(4'b0000, 4'b0001, 4'b0001, 4'b0000);
        tick(); tick();
        @(negedge clk);
        chk("rst_en", o_en, 4'b0000);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_entry", o_entry, 2'd0);
        chk("rst_payload", o_payload, 64'd0);
        chk("rst_fwd", {o_src0_forward_alu, o_src1_forward_alu}, 2'b00);
        tick();
        reset = 1'b0;
        drive(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick();

        // Slot 2 allocated before slot 0: age beats position.
        drive(4'b0100, 4'b0100, 4'b0000, 4'b0000); cyc("age_t0", 4'b0000, 1, 0); tick();
        drive(4'b0001, 4'b0101, 4'b0000, 4'b0000); cyc("age_t1", 4'b0000, 1, 0); tick();
        drive(4'b0000, 4'b0101, 4'b0101, 4'b0000); cyc("age_t2", 4'b0100, 1, 0); tick();
        drive(4'b0000, 4'b0001, 4'b0001, 4'b0000); cyc("age_t3", 4'b0001, 1, 0);
        chk("age_t3_entry", o_entry, 2'd2); tick();
        drive(4'b0000, 4'b0000, 4'b0000, 4'b0000); cyc("age_t4", 4'b0000, 1, 0); tick();
        @(negedge clk); chk("age_drain_valid", o_valid, 1'b0); tick();

        // Same-cycle allocation of 1 and 3: lower index is older.
        drive(4'b1010, 4'b1010, 4'b0000, 4'b0000); cyc("sim_t0", 4'b0000, 1, 0); tick();
        drive(4'b0000, 4'b1010, 4'b1010, 4'b0000); cyc("sim_t1", 4'b0010, 1, 0); tick();
        drive(4'b0000, 4'b1000, 4'b1000, 4'b0000); cyc("sim_t2", 4'b1000, 1, 0); tick();
        drive(4'b0000, 4'b0000, 4'b0000, 4'b0000); cyc("sim_t3", 4'b0000, 1, 0); tick();

        // Oldest op is memory and snoop blocks it; younger ALU op goes first.
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0001); cyc("snp_t0", 4'b0000, 1, 0); tick();
        drive(4'b0010, 4'b0011, 4'b0000, 4'b0001); cyc("snp_t1", 4'b0000, 1, 0); tick();
        snoop_hit = 1'b1;
        drive(4'b0000, 4'b0011, 4'b0011, 4'b0001); cyc("snp_t2", 4'b0010, 1, 0); tick();
        drive(4'b0000, 4'b0001, 4'b0001, 4'b0001); cyc("snp_t3", 4'b0000, 1, 0); tick();
        snoop_hit = 1'b0;
        cyc("snp_t4", 4'b0001, 1, 0); tick();
        drive(4'b0000, 4'b0000, 4'b0000, 4'b0000); cyc("snp_t5", 4'b0000, 1, 0); tick();

        // Downstream stall for three cycles with slot 3 waiting.
        drive(4'b1100, 4'b1100, 4'b0000, 4'b0000); cyc("hld_t0", 4'b0000, 1, 0); tick();
        drive(4'b0000, 4'b1100, 4'b1100, 4'b0000); cyc("hld_t1", 4'b0100, 1, 0); tick();
        o_ready = 1'b0;
        drive(4'b0000, 4'b1000, 4'b1000, 4'b0000);
        for (int c = 0; c < 3; c++) begin
            cyc("hld_stall_en", 4'b0000, 1, 0);
            chk("hld_stall_valid", o_valid, 1'b1);
            chk("hld_stall_entry", o_entry, 2'd2);
            chk("hld_stall_payload", o_payload, pl(2));
            tick();
        end
        o_ready = 1'b1;
        cyc("hld_release", 4'b1000, 1, 0); tick();
        drive(4'b0000, 4'b0000, 4'b0000, 4'b0000); cyc("hld_t6", 4'b0000, 1, 0); tick();

        // Branch flush discards a stalled op and blocks picking that cycle.
        drive(4'b0011, 4'b0011, 4'b0000, 4'b0000); cyc("bco_t0", 4'b0000, 1, 0); tick();
        o_ready = 1'b0;
        drive(4'b0000, 4'b0011, 4'b0011, 4'b0000); cyc("bco_t1", 4'b0001, 0, 0); tick();
        bco_valid = 1'b1;
        drive(4'b0000, 4'b0010, 4'b0010, 4'b0000); cyc("bco_t2", 4'b0000, 1, 0);
        chk("bco_t2_held", o_valid, 1'b1); tick();
        bco_valid = 1'b0; o_ready = 1'b1;
        cyc("bco_t3", 4'b0010, 1, 0);
        chk("bco_t3_flushed", o_valid, 1'b0); tick();
        drive(4'b0000, 4'b0000, 4'b0000, 4'b0000); cyc("bco_t4", 4'b0000, 1, 0); tick();

        // ALU bypass for src1 of slot 0 (tag 5).
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0000); cyc("fwd_t0", 4'b0000, 1, 0); tick();
        i_alloc = '0; i_src0_rdy = 4'b0001; i_src1_rdy = 4'b0000;
        i_src1_rob[RW-1:0] = 4'd5; i_fwd_valid = 1'b1; i_fwd_rob = 4'd4;
        cyc("fwd_tag_miss", 4'b0000, 1, 0); tick();
        i_fwd_rob = 4'd5;
`ifdef ISSUE_PICK_FORWARD_EN
        cyc("fwd_tag_hit", 4'b0001, 1, 1); tick();
`else
        cyc("fwd_tag_hit", 4'b0000, 1, 0); tick();
`endif
        i_fwd_valid = 1'b0;
        drive(4'b0000, 4'b0000, 4'b0000, 4'b0000); cyc("fwd_t3", 4'b0000, 1, 0); tick();

        tick(); tick();
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
